// File: rtl/uart_receiver.sv
// 8N1 UART receiver: 2-flop input synchroniser, mid-bit sampling driven by a
// 32-bit baud down-counter, one-cycle valid / framing-error pulses.
module uart_receiver #(
    parameter int unsigned CLOCKS_PER_BAUD = 868
) (
    input  logic       i_CLK,
    input  logic       i_RESET,
    input  logic       i_RX,
    output logic [7:0] o_DATA_OUT,
    output logic       o_RX_VALID,
    output logic       o_RX_BUSY,
    output logic       o_FRAME_ERROR
);

    localparam int unsigned HALF_BAUD   = CLOCKS_PER_BAUD / 2;
    localparam logic [31:0] BAUD_RELOAD = 32'(CLOCKS_PER_BAUD - 1);
    localparam logic [31:0] HALF_RELOAD = 32'(HALF_BAUD - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP,
        S_BREAK
    } state_t;

    state_t      state;
    logic        rx_meta;
    logic        rx_s;
    logic [31:0] baud_cnt;
    logic [2:0]  bit_idx;
    logic [7:0]  shift_reg;
    logic        sample;

    // Bring the asynchronous serial line into the i_CLK domain; idles high.
    always_ff @(posedge i_CLK) begin
        if (i_RESET) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
        end else begin
            rx_meta <= i_RX;
            rx_s    <= rx_meta;
        end
    end

    assign sample = (baud_cnt == '0);

    // Frame FSM: start detection, mid-bit sampling, stop-bit check, break wait.
    always_ff @(posedge i_CLK) begin
        if (i_RESET) begin
            state         <= S_IDLE;
            baud_cnt      <= '0;
            bit_idx       <= '0;
            shift_reg     <= '0;
            o_DATA_OUT    <= '0;
            o_RX_VALID    <= 1'b0;
            o_FRAME_ERROR <= 1'b0;
        end else begin
            o_RX_VALID    <= 1'b0;
            o_FRAME_ERROR <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (!rx_s) begin
                        baud_cnt <= HALF_RELOAD;
                        state    <= S_START;
                    end
                end
                S_START: begin
                    if (sample) begin
                        baud_cnt <= BAUD_RELOAD;
                        if (!rx_s) begin
                            bit_idx <= '0;
                            state   <= S_DATA;
                        end else begin
                            // Start bit gone by mid-point: treat as a glitch.
                            state <= S_IDLE;
                        end
                    end else begin
                        baud_cnt <= baud_cnt - 32'd1;
                    end
                end
                S_DATA: begin
                    if (sample) begin
                        shift_reg <= {rx_s, shift_reg[7:1]};
                        bit_idx   <= bit_idx + 3'd1;
                        baud_cnt  <= BAUD_RELOAD;
                        if (bit_idx == 3'd7) begin
                            state <= S_STOP;
                        end
                    end else begin
                        baud_cnt <= baud_cnt - 32'd1;
                    end
                end
                S_STOP: begin
                    if (sample) begin
                        baud_cnt <= BAUD_RELOAD;
                        if (rx_s) begin
                            o_DATA_OUT <= shift_reg;
                            o_RX_VALID <= 1'b1;
                            state      <= S_IDLE;
                        end else begin
                            o_FRAME_ERROR <= 1'b1;
                            state         <= S_BREAK;
                        end
                    end else begin
                        baud_cnt <= baud_cnt - 32'd1;
                    end
                end
                S_BREAK: begin
                    // Held-low line: wait for idle so a break yields one error only.
                    if (rx_s) begin
                        state <= S_IDLE;
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    // Busy is a pure decode of the frame-in-progress states.
    always_comb begin
        o_RX_BUSY = (state == S_START) || (state == S_DATA) || (state == S_STOP);
    end

endmodule

// File: tb/tb_uart_receiver.sv
// Scoreboard bench for uart_receiver: stimulus pushes expected events,
// per-DUT monitors pop and compare whenever a valid/error pulse appears.
module tb_uart_receiver;

    typedef struct {
        bit         err;
        logic [7:0] data;
        longint     stamp;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst;
    logic       rx_a;
    logic       rx_b;
    logic [7:0] data_a, data_b;
    logic       valid_a, valid_b;
    logic       busy_a, busy_b;
    logic       err_a, err_b;

    longint     cyc = 0;
    int         checks = 0;
    int         fails = 0;
    exp_t       q0[$];
    exp_t       q1[$];
    logic [7:0] last_good0 = 8'h00;
    logic [7:0] last_good1 = 8'h00;

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    uart_receiver #(.CLOCKS_PER_BAUD(16)) dut (
        .i_CLK         (clk),
        .i_RESET       (rst),
        .i_RX          (rx_a),
        .o_DATA_OUT    (data_a),
        .o_RX_VALID    (valid_a),
        .o_RX_BUSY     (busy_a),
        .o_FRAME_ERROR (err_a)
    );

    uart_receiver #(.CLOCKS_PER_BAUD(868)) dut_lb (
        .i_CLK         (clk),
        .i_RESET       (rst),
        .i_RX          (rx_b),
        .o_DATA_OUT    (data_b),
        .o_RX_VALID    (valid_b),
        .o_RX_BUSY     (busy_b),
        .o_FRAME_ERROR (err_b)
    );

    task automatic chk(input string name, input longint act, input longint req);
        checks++;
        if (act != req) begin
            fails++;
            $display("FAIL %s: got %0h, required %0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Pop and compare one output event from the given DUT.
    task automatic mon(input int which, input logic v, input logic er, input logic [7:0] d);
        exp_t e;
        if (v && er) begin
            checks++;
            fails++;
            $display("FAIL exclusive_%0d: valid and frame_error both high at cycle %0d", which, cyc);
        end
        if (v || er) begin
            if ((which == 0 && q0.size() == 0) || (which == 1 && q1.size() == 0)) begin
                checks++;
                fails++;
                $display("FAIL unexpected_%0d: valid=%0b err=%0b data=%02h, required no event (cycle %0d)",
                         which, v, er, d, cyc);
            end else begin
                e = (which == 0) ? q0.pop_front() : q1.pop_front();
                chk($sformatf("kind_err_%0d", which), longint'(er), longint'(e.err));
                chk($sformatf("data_%0d", which), longint'(d), longint'(e.data));
                chk($sformatf("latency_%0d", which), cyc, e.stamp);
            end
        end
    endtask

    always @(negedge clk) mon(0, valid_a, err_a, data_a);
    always @(negedge clk) mon(1, valid_b, err_b, data_b);

    task automatic set_line(input int which, input logic b);
        if (which == 0) rx_a = b;
        else            rx_b = b;
    endtask

    // Drive one 8N1 frame from a negedge; queue the event it must produce.
    task automatic send(input int which, input logic [7:0] d, input logic stop, input int cpb);
        exp_t e;
        logic [7:0] dv;
        dv      = d;
        e.err   = !stop;
        e.stamp = cyc + longint'(cpb / 2) + 9 * longint'(cpb) + 3;
        if (which == 0) begin
            e.data = stop ? dv : last_good0;
            if (stop) last_good0 = dv;
            q0.push_back(e);
        end else begin
            e.data = stop ? dv : last_good1;
            if (stop) last_good1 = dv;
            q1.push_back(e);
        end
        set_line(which, 1'b0);
        repeat (cpb) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            set_line(which, dv[i]);
            repeat (cpb) @(negedge clk);
        end
        set_line(which, stop);
        repeat (cpb) @(negedge clk);
    endtask

    task automatic drain(input int which, input int budget);
        int n;
        n = 0;
        while (((which == 0) ? q0.size() : q1.size()) != 0 && n < budget) begin
            @(negedge clk);
            n++;
        end
        chk($sformatf("drain_%0d", which), longint'((which == 0) ? q0.size() : q1.size()), 0);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int busy_cnt;
        rst  = 1'b1;
        rx_a = 1'b1;
        rx_b = 1'b1;
        repeat (5) @(negedge clk);
        chk("reset_data", longint'(data_a), 0);
        chk("reset_valid", longint'(valid_a), 0);
        chk("reset_busy", longint'(busy_a), 0);
        chk("reset_err", longint'(err_a), 0);
        rst = 1'b0;
        repeat (4) @(negedge clk);

        // Single good frame, fixed latency from the falling edge
        send(0, 8'hA5, 1'b1, 16);
        repeat (10) @(negedge clk);
        drain(0, 200);
        chk("a5_hold", longint'(data_a), 8'hA5);

        // Three-cycle glitch: busy for exactly the START window, no pulses
        busy_cnt = 0;
        rx_a = 1'b0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (busy_a) busy_cnt++;
            if (i == 2) rx_a = 1'b1;
        end
        chk("glitch_busy_cycles", longint'(busy_cnt), 8);
        chk("glitch_idle", longint'(busy_a), 0);

        // Good frame, then a framing error held into a break
        send(0, 8'hA5, 1'b1, 16);
        send(0, 8'h3C, 1'b0, 16);
        repeat (20) @(negedge clk);
        chk("break_busy", longint'(busy_a), 0);
        repeat (20) @(negedge clk);
        chk("break_data_hold", longint'(data_a), 8'hA5);
        rx_a = 1'b1;
        drain(0, 50);
        repeat (16) @(negedge clk);
        send(0, 8'h11, 1'b1, 16);
        repeat (10) @(negedge clk);
        drain(0, 200);

        // Back-to-back frames, no idle gap
        send(0, 8'h00, 1'b1, 16);
        send(0, 8'hFF, 1'b1, 16);
        repeat (10) @(negedge clk);
        drain(0, 200);
        chk("b2b_last", longint'(data_a), 8'hFF);

        // Reset in the middle of 0x81 (after its 4th data bit)
        rx_a = 1'b0;
        repeat (16) @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            rx_a = (i == 0) ? 1'b1 : 1'b0;
            repeat (16) @(negedge clk);
        end
        rx_a = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("midrst_data", longint'(data_a), 0);
        chk("midrst_valid", longint'(valid_a), 0);
        chk("midrst_busy", longint'(busy_a), 0);
        chk("midrst_err", longint'(err_a), 0);
        last_good0 = 8'h00;
        rst  = 1'b0;
        rx_a = 1'b1;
        repeat (30) @(negedge clk);
        chk("postrst_idle", longint'(busy_a), 0);
        send(0, 8'h5A, 1'b1, 16);
        repeat (10) @(negedge clk);
        drain(0, 200);
        chk("postrst_data", longint'(data_a), 8'h5A);

        // Full-rate loopback at 868 clocks per bit
        send(1, 8'h00, 1'b1, 868);
        send(1, 8'h55, 1'b1, 868);
        send(1, 8'hFF, 1'b1, 868);
        send(1, 8'h5A, 1'b1, 868);
        repeat (10) @(negedge clk);
        drain(1, 2000);
        chk("lb_last", longint'(data_b), 8'h5A);
        repeat (20) @(negedge clk);
        chk("final_q0", longint'(q0.size()), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
